rr_req_arbiter16: RTL

- Round-robin arbiter in front of the 16-to-4 priority encoder. It takes 16 independent request lines and issues exactly one registered one-hot grant at a time.
- The one-hot grant vector drives the encoder's 16-bit binary input directly. The encoder therefore only ever sees zero or a single set bit.
- The downstream consumer returns ack to release the grant. A timeout revokes a grant that is never acknowledged.

---
 rtl/rr_req_arbiter16_if.sv | 39 +++
 rtl/rr_req_arbiter16.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter16_if.sv
// Bus between the round-robin arbiter and its requesters/consumer.
// Optional macro ARB_INDEX_EN adds the grant_idx signal.
//
// Handshake: the arbiter raises one bit of grant (grant_valid=1) and holds
// it until the consumer asserts ack for one cycle, or until the timeout
// revokes it. ack is only sampled while a grant is held. A released grant
// is always followed by at least one all-zero cycle.
interface rr_req_arbiter16_if;
  logic        enable;
  logic [15:0] req;
  logic        ack;
  logic [15:0] grant;
  logic        grant_valid;
  logic        busy;
  logic        timeout;
`ifdef ARB_INDEX_EN
  logic [3:0]  grant_idx;

  modport master (
    output enable, req, ack,
    input  grant, grant_valid, busy, timeout, grant_idx
  );

  modport slave (
    input  enable, req, ack,
    output grant, grant_valid, busy, timeout, grant_idx
  );
`else
  modport master (
    output enable, req, ack,
    input  grant, grant_valid, busy, timeout
  );

  modport slave (
    input  enable, req, ack,
    output grant, grant_valid, busy, timeout
  );
`endif
endinterface

// File: rtl/rr_req_arbiter16.sv
// Round-robin arbiter feeding a 16-to-4 priority encoder with a one-hot grant.
// Optional macro ARB_INDEX_EN adds a registered grant_idx output.
// dbg_state exposes the FSM state (0 = IDLE, 1 = GRANT).
module rr_req_arbiter16 #(
  parameter int N       = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_req_arbiter16_if.slave bus,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value on which an unacknowledged grant is revoked.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [N-1:0]    ONE     = {{(N-1){1'b0}}, 1'b1};

  state_t          state, state_n;
  logic [N-1:0]    grant_q, grant_n;
  logic [3:0]      ptr, ptr_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic            timeout_q, timeout_n;

  logic            sel_found;
  logic [3:0]      sel_idx;
  logic [3:0]      cur_idx;
  logic            start;

  // Pick the first requester at or above ptr, wrapping 15 -> 0. The loop
  // runs from the farthest distance down so the closest requester wins.
  always_comb begin : pick
    logic [3:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = ptr;
    for (int d = N - 1; d >= 0; d--) begin
      cand = ptr + 4'(d);
      if (bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Binary index of the currently held grant, used to advance ptr on release.
  always_comb begin : encode
    cur_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) cur_idx = 4'(i);
    end
  end

  assign start = (state == IDLE) && bus.enable && sel_found;

  // Next-state logic: issue in IDLE, release on ack or timeout in GRANT.
  always_comb begin : next_state
    state_n   = state;
    grant_n   = grant_q;
    ptr_n     = ptr;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          grant_n = ONE << sel_idx;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          // ack wins over a coincident timeout, so no pulse here.
          grant_n = '0;
          ptr_n   = cur_idx + 4'd1;
          state_n = IDLE;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          grant_n   = '0;
          ptr_n     = cur_idx + 4'd1;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State register; reset drops any grant immediately and rewinds ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      ptr       <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

`ifdef ARB_INDEX_EN
  logic [3:0] idx_q;

  // Index of the last issued grant; held while no grant is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (start) begin
      idx_q <= sel_idx;
    end
  end

  assign bus.grant_idx = idx_q;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.busy        = (state == GRANT);
  assign bus.timeout     = timeout_q;
  assign dbg_state       = state;

  // The encoder downstream must never see more than one set bit.
  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  // A grant is present exactly while the FSM sits in GRANT.
  a_busy_grant : assert property (@(posedge clk) disable iff (!rst_n)
    (state == GRANT) == (grant_q != '0));

endmodule
